// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: operation codes, FSM states and iteration count for the mul/div unit.
// Rev 1.0
`default_nettype none

package mips_cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int ITER_COUNT = 32;

endpackage

`default_nettype wire

// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: request/result bundle between the execute stage and the mul/div unit.
// Rev 1.0
`default_nettype none

interface mips_cpu_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, A, B, input busy, done, hi, lo);
  modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

`default_nettype wire

// File: rtl/mips_cpu_div_step.sv
// mips_cpu_div_step: one combinational restoring-division step on (remainder, quotient, divisor).
// Rev 1.0
`default_nettype none

module mips_cpu_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);
  logic [32:0] shifted;
  logic [32:0] diff;

  // rem < divisor always holds, so the 33-bit difference borrows exactly when shifted < divisor
  assign shifted  = {rem, quo[31]};
  assign diff     = shifted - {1'b0, divisor};
  assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_next = {quo[30:0], ~diff[32]};
endmodule

`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: 34-cycle iterative MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Rev 1.0 -- MIPS_CPU_MULDIV_FAST_MUL_EN selects single-cycle MULT/MULTU.
`default_nettype none

module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mips_cpu_muldiv_if.slave md
);
  state_t      state, state_next;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] operand;
  logic        is_div, neg_res, neg_rem, div_zero;
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg, busy;

  logic        signed_op, div_op, start_iter, last_iter;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [31:0] rem_next, quo_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, hi_res, lo_res;

  assign signed_op = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign div_op    = (md.op == MD_DIV) || (md.op == MD_DIVU);
  assign mag_a     = (signed_op && md.A[31]) ? -md.A : md.A;
  assign mag_b     = (signed_op && md.B[31]) ? -md.B : md.B;
  assign last_iter = (count == 5'(ITER_COUNT - 1));

`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
  logic        fast_go;
  logic [63:0] fast_a, fast_b, fast_prod;
  assign fast_go    = (state == ST_IDLE) && md.start && (md.op == MD_MULT || md.op == MD_MULTU);
  assign fast_a     = signed_op ? {{32{md.A[31]}}, md.A} : {32'd0, md.A};
  assign fast_b     = signed_op ? {{32{md.B[31]}}, md.B} : {32'd0, md.B};
  assign fast_prod  = fast_a * fast_b;
  assign start_iter = (state == ST_IDLE) && md.start && div_op;
`else
  assign start_iter = (state == ST_IDLE) && md.start &&
                      (div_op || md.op == MD_MULT || md.op == MD_MULTU);
`endif

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
  assign mul_next = {mul_sum, acc[31:1]};

  // Divide: acc = {remainder, quotient/dividend}
  mips_cpu_div_step u_div_step (
    .rem      (acc[63:32]),
    .quo      (acc[31:0]),
    .divisor  (operand),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
  assign hi_res   = is_div ? rem_fix : prod_fix[63:32];
  assign lo_res   = is_div ? (div_zero ? 32'hFFFF_FFFF : quo_fix) : prod_fix[31:0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_iter) state_next = ST_RUN;
      ST_RUN:  if (last_iter)  state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 5'd0;
      acc      <= 64'd0;
      operand  <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state == ST_IDLE && md.start) begin
        if (md.op == MD_MTHI) hi_reg <= md.A;
        if (md.op == MD_MTLO) lo_reg <= md.A;
      end
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
      if (fast_go) begin
        {hi_reg, lo_reg} <= fast_prod;
        done_reg         <= 1'b1;
      end
`endif
      if (start_iter) begin
        is_div   <= div_op;
        neg_res  <= signed_op & (md.A[31] ^ md.B[31]);
        neg_rem  <= signed_op & md.A[31];
        div_zero <= div_op & (md.B == 32'd0);
        count    <= 5'd0;
        if (div_op) begin
          acc     <= {32'd0, mag_a};
          operand <= mag_b;
        end else begin
          acc     <= {32'd0, mag_b};
          operand <= mag_a;
        end
      end
      if (state == ST_RUN) begin
        acc   <= is_div ? {rem_next, quo_next} : mul_next;
        count <= count + 5'd1;
      end
      if (state == ST_FIX) begin
        hi_reg   <= hi_res;
        lo_reg   <= lo_res;
        done_reg <= 1'b1;
      end
    end
  end

  assign md.busy = busy;
  assign md.done = done_reg;
  assign md.hi   = hi_reg;
  assign md.lo   = lo_reg;
endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: scoreboard bench for the mul/div unit (honours MIPS_CPU_MULDIV_FAST_MUL_EN).
// Rev 1.0
`default_nettype none

module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mips_cpu_muldiv_if bus ();

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    res_t        res;
    res.hi = m_hi;
    res.lo = m_lo;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      MD_MULT:  begin p = sa * sb; res.hi = p[63:32]; res.lo = p[31:0]; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; res.hi = p[63:32]; res.lo = p[31:0]; end
      MD_DIV: begin
        if (b == 32'd0) begin res.hi = a; res.lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; res.lo = 32'(q); res.hi = 32'(r); end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin res.hi = a; res.lo = 32'hFFFF_FFFF; end
        else begin res.lo = a / b; res.hi = a % b; end
      end
      MD_MTHI: res.hi = a;
      MD_MTLO: res.lo = a;
      default: ;
    endcase
    return res;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input logic [31:0] inj_a);
    res_t        e;
    int          n, lat;
    logic        exp_busy;
    logic [31:0] hi0, lo0;
    exp_q.push_back(model(op, a, b));
    lat      = 34;
    exp_busy = 1'b1;
`ifdef MIPS_CPU_MULDIV_FAST_MUL_EN
    if (op == MD_MULT || op == MD_MULTU) begin
      lat      = 1;
      exp_busy = 1'b0;
    end
`endif
    hi0 = bus.hi;
    lo0 = bus.lo;
    drive(op, a, b);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      if (n == 1) chk("busy_after_start", bus.busy, exp_busy);
      if (n == 10 && lat > 1) begin
        chk("hi_stable_in_run", bus.hi, hi0);
        chk("lo_stable_in_run", bus.lo, lo0);
      end
      if (inj_at != 0 && n == inj_at) drive(MD_MTLO, inj_a, 32'd0);
      if (inj_at != 0 && n == inj_at + 2) chk("mtlo_while_busy_ignored", bus.lo, lo0);
    end while (!bus.done && n < 100);
    chk("latency", n, lat);
    e = exp_q.pop_front();
    chk("hi_result", bus.hi, e.hi);
    chk("lo_result", bus.lo, e.lo);
    chk("busy_at_done", bus.busy, 1'b0);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    res_t e;
    e = model(op, a, 32'd0);
    drive(op, a, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m_hi = e.hi;
    m_lo = e.lo;
    chk("mt_hi", bus.hi, e.hi);
    chk("mt_lo", bus.lo, e.lo);
    chk("mt_busy", bus.busy, 1'b0);
    chk("mt_done", bus.done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_cnt;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    reset = 1'b0;

    run_op(MD_MULT,  32'hFFFF_FFFF, 32'd2, 0, 32'd0);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 32'd0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0, 32'd0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run_op(MD_DIVU,  32'd7, 32'd0, 0, 32'd0);
    run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0, 0, 32'd0);
    run_op(MD_DIVU,  32'd1000, 32'd7, 10, 32'hDEAD_BEEF);

    @(posedge clk);
    #1;
    chk("done_single_pulse", bus.done, 1'b0);

    drive(3'd6, 32'h55, 32'h66);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("noop_hi", bus.hi, m_hi);
    chk("noop_lo", bus.lo, m_lo);
    chk("noop_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    chk("noop_done", bus.done, 1'b0);

    mt(MD_MTHI, 32'h1234_5678);
    mt(MD_MTLO, 32'hABCD_EF01);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      run_op(3'($urandom_range(0, 3)), ra, rb, 0, 32'd0);
    end

    mt(MD_MTHI, 32'h1234_5678);
    drive(MD_DIVU, 32'd100, 32'd3);
    n = 0;
    while (n < 15) begin
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", bus.busy, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    run_op(MD_MULT, 32'd3, 32'hFFFF_FFFB, 0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage. It takes the same rs/rt operand buses (A, B) that feed the ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and exposes HI/LO to the writeback mux for MFHI/MFLO. While it is busy, the control unit stalls any instruction that touches HI/LO.

## Interface
- Parameters: none. Operation encodings come from the package.
- Clock and reset: single clock; synchronous, active-high reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset.
- start  in  1  request; sampled on the rising edge of clk.
- op  in  3  operation code, from mips_cpu_muldiv_pkg:
  - MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - Codes 6 and 7 are no-ops.
- A  in  32  rs value (multiplicand / dividend / MTHI/MTLO source).
- B  in  32  rt value (multiplier / divisor).
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; HI/LO have just been updated by a MULT/MULTU/DIV/DIVU.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start with op MD_MTHI or MD_MTLO:
  - hi (or lo) ← A at that edge.
  - Stays in IDLE; no busy, no done.
- IDLE, start with op MULT/MULTU/DIV/DIVU:
  - Latch the operands as magnitudes when signed, raw when unsigned.
  - Record the result signs; count ← 0; go to RUN.
- RUN, one iteration per cycle, 32 iterations total; count goes 0..31, then → FIX:
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring shift-subtract; 32-bit quotient, 32-bit remainder.
- FIX, then IDLE with done:
  - Negate the 64-bit product if the operand signs differ (signed op only).
  - Negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write {hi,lo}: product → {hi,lo}; quotient → lo, remainder → hi.
- Divide by zero (B==0, DIV or DIVU): lo ← 32'hFFFFFFFF, hi ← A, regardless of sign.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo ← 32'h80000000, hi ← 0. This is the natural result of the magnitude algorithm and must not trap.
- start while busy is ignored, including MTHI/MTLO. Holding off such instructions is the control unit's job.
- start in the same cycle as done: accepted normally. The new op's latch uses the freshly written HI/LO only for MTHI/MTLO semantics (not applicable otherwise).
- Codes 6 and 7 with start: no effect.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, count=0.
- Reset during RUN/FIX aborts the operation: no done, HI/LO cleared.
- start sampled at edge E0 → busy=1 from E0 to E33.
- Iterations complete at edges E1..E32.
- FIX writes HI/LO at E33; busy=0 and done=1 for the single cycle after E33.
- MULT/MULTU/DIV/DIVU latency: 34 cycles from start to done.
- MTHI/MTLO: the value is visible on hi/lo the cycle after start.
- hi/lo stay stable throughout RUN; they hold their previous values until E33.

## Configuration
- MIPS_CPU_MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU complete in one cycle: signed/unsigned 64-bit `*`, written to {hi,lo} at E0.
  - done pulses in the cycle after E0; busy never asserts.
  - DIV/DIVU unchanged, 34 cycles.
- Undefined: all four operations use the iterative path, 34 cycles each.

## Structure
- mips_cpu_muldiv_pkg holds the op enum (MD_*), the state enum, and the ITER_COUNT=32 constant.
- Sub-module mips_cpu_div_step is combinational, one restoring-division step: (rem, quo, divisor) → (rem', quo'). It is instantiated once and reused each RUN cycle.

## Test plan
- MULT A=32'hFFFFFFFF, B=2 → done at cycle 34; hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
- MULTU A=32'hFFFFFFFF, B=2 → hi=1, lo=32'hFFFFFFFE.
  - With FAST_MUL_EN, done arrives the cycle after start and busy stays 0.
- DIV A=-7 (32'hFFFFFFF9), B=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV A=32'h80000000, B=32'hFFFFFFFF → lo=32'h80000000, hi=0.
- DIVU A=7, B=0 → lo=32'hFFFFFFFF, hi=7. Then start an MTLO at cycle 10 of a subsequent DIVU → the MTLO is ignored and lo = that DIVU's quotient.
- MTHI A=32'h12345678, then start a DIVU, and assert reset at cycle 15 → hi=lo=0, busy=0, no done pulse.
